// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM state encoding and ALU opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } seq_state_e;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_MOD  = 3'b110;
  localparam logic [OP_W-1:0] OP_DIV  = 3'b111;

  // Opcodes whose Y operand is a divisor and must be non-zero.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_MOD) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the command, ALU and result ports of the sequencer.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready in, res_valid/res_ready out.
interface alu_cmd_sequencer_if #(
  parameter int Data_width = 32,
  parameter int TAG_W      = 4
);
  import alu_seq_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [Data_width-1:0] cmd_x;
  logic [Data_width-1:0] cmd_y;
  logic [OP_W-1:0]       cmd_op;
  logic [TAG_W-1:0]      cmd_tag;

  logic [Data_width-1:0] alu_x;
  logic [Data_width-1:0] alu_y;
  logic [OP_W-1:0]       alu_op;
  logic [Data_width:0]   alu_z;

  logic                  res_valid;
  logic                  res_ready;
  logic [Data_width:0]   res_data;
  logic                  res_err;
  logic [TAG_W-1:0]      res_tag;

  // Command producer / result consumer / ALU side.
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_op, cmd_tag, res_ready, alu_z,
    input  cmd_ready, res_valid, res_data, res_err, res_tag, alu_x, alu_y, alu_op
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_op, cmd_tag, res_ready, alu_z,
    output cmd_ready, res_valid, res_data, res_err, res_tag, alu_x, alu_y, alu_op
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, no bypass; count/full/empty are registered state.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: full_o is held high during reset and blocks pushes even when a pop coincides.
module alu_cmd_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              wdata_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_o;
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Occupancy after this edge; also feeds the registered full flag.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers, count and full flag; full resets high so no push lands before release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to a registered ALU and returns tagged results.
// Latency: 3 cycles from pop to res_valid for ALU ops, 1 cycle for a trapped zero divisor.
// Backpressure: cmd_ready is !full of the command FIFO; res_valid holds until res_ready.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int Data_width = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  alu_cmd_sequencer_if.slave bus
);
  localparam int CMD_W = 2*Data_width + OP_W + TAG_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CMD_W-1:0]      fifo_wdata, fifo_rdata;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [Data_width-1:0] head_x, head_y;
  logic [OP_W-1:0]       head_op;
  logic [TAG_W-1:0]      head_tag;
  logic                  div_by_zero;

  seq_state_e            state_q, state_d;
  logic [Data_width-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [OP_W-1:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [Data_width:0]   res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;
  logic [TAG_W-1:0]      res_tag_q, res_tag_d;

  assign bus.cmd_ready = ~fifo_full;
  assign fifo_push     = bus.cmd_valid & ~fifo_full;
  assign fifo_wdata    = {bus.cmd_x, bus.cmd_y, bus.cmd_op, bus.cmd_tag};
  assign {head_x, head_y, head_op, head_tag} = fifo_rdata;
  assign div_by_zero   = is_div_op(head_op) && (head_y == '0);

  assign bus.alu_x     = alu_x_q;
  assign bus.alu_y     = alu_y_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_tag   = res_tag_q;

  alu_cmd_fifo #(
    .WIDTH      (CMD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // The FIFO's empty flag and count are separate registers views; they must agree.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (fifo_empty == (fifo_cnt == '0));
    end
  end

  // Next state and register loads; pops only from IDLE, one command in flight.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    alu_op_d   = alu_op_q;
    tag_d      = tag_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    res_tag_d  = res_tag_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (div_by_zero) begin
            // Never reaches the ALU; the operand registers keep the last issued command.
            res_data_d = '1;
            res_err_d  = 1'b1;
            res_tag_d  = head_tag;
            state_d    = HOLD;
          end else begin
            alu_x_d  = head_x;
            alu_y_d  = head_y;
            alu_op_d = head_op;
            tag_d    = head_tag;
            state_d  = WAIT;
          end
        end
      end
      // ALU registers output_Z at the end of this cycle.
      WAIT: state_d = CAPTURE;
      CAPTURE: begin
        res_data_d = bus.alu_z;
        res_err_d  = 1'b0;
        res_tag_d  = tag_q;
        state_d    = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, ALU operand and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_op_q   <= '0;
      tag_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      res_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      alu_op_q   <= alu_op_d;
      tag_q      <= tag_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      res_tag_q  <= res_tag_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural registered 32-bit ALU.
// Latency: n/a.
// Backpressure: res_ready is driven by the bench to exercise HOLD and queue capacity.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 32;
  localparam int TW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.Data_width(DW), .TAG_W(TW)) bus ();

  alu_cmd_sequencer #(
    .Data_width (DW),
    .FIFO_DEPTH (4),
    .TAG_W      (TW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  // Registered ALU: output_Z follows the operands one clock later.
  function automatic logic [DW:0] alu_fn(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                         input logic [2:0] op);
    case (op)
      OP_ADD:  return {1'b0, x} + {1'b0, y};
      OP_SUB:  return {1'b0, x} - {1'b0, y};
      OP_AND:  return {1'b0, x & y};
      OP_OR:   return {1'b0, x | y};
      OP_XOR:  return {1'b0, x ^ y};
      OP_XNOR: return {1'b0, ~(x ^ y)};
      OP_MOD:  return (y == '0) ? '1 : {1'b0, x % y};
      default: return (y == '0) ? '1 : {1'b0, x / y};
    endcase
  endfunction

  always_ff @(posedge clk) bus.alu_z <= alu_fn(bus.alu_x, bus.alu_y, bus.alu_op);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one command for one edge (called and returning at a negedge).
  task automatic push(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                      input logic [TW-1:0] tag, output logic acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_tag   = tag;
    acc = bus.cmd_ready;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, check it, then accept it with a one-edge res_ready.
  task automatic expect_res(input string tag, input logic [DW:0] d, input logic e,
                            input logic [TW-1:0] t);
    int waited = 0;
    while (!bus.res_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_vld"}, 64'(bus.res_valid), 64'(1));
    chk({tag, "_data"}, 64'(bus.res_data), 64'(d));
    chk({tag, "_err"}, 64'(bus.res_err), 64'(e));
    chk({tag, "_tag"}, 64'(bus.res_tag), 64'(t));
    if (bus.res_valid) begin
      bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_op    = '0;
    bus.cmd_tag   = '0;
    bus.res_ready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_vld",  64'(bus.res_valid), 64'(0));
    chk("rst_rdy",  64'(bus.cmd_ready), 64'(0));
    chk("rst_data", 64'(bus.res_data),  64'(0));
    chk("rst_alux", 64'(bus.alu_x),     64'(0));
    chk("rst_aluop", 64'(bus.alu_op),   64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 64'(bus.cmd_ready), 64'(1));

    // ADD with carry out, latency 3 edges after acceptance.
    push(OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3, acc);
    chk("add_acc", 64'(acc), 64'(1));
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      chk($sformatf("add_lat%0d", cyc), 64'(bus.res_valid), 64'(cyc == 3));
    end
    expect_res("add", 33'h1_0000_0000, 1'b0, 4'd3);

    // SUB wrap, DIV, MOD returned in push order.
    push(OP_SUB, 32'd3,   32'd5, 4'd1, acc);
    push(OP_DIV, 32'd100, 32'd7, 4'd2, acc);
    push(OP_MOD, 32'd100, 32'd7, 4'd4, acc);
    expect_res("sub", 33'h1_FFFF_FFFE, 1'b0, 4'd1);
    expect_res("div", 33'd14, 1'b0, 4'd2);
    expect_res("mod", 33'd2,  1'b0, 4'd4);

    // Divide by zero: trapped, result one edge after pop, ALU operands untouched.
    push(OP_DIV, 32'd9, 32'd0, 4'd5, acc);
    chk("dz_lat0", 64'(bus.res_valid), 64'(0));
    @(negedge clk);
    chk("dz_lat1", 64'(bus.res_valid), 64'(1));
    chk("dz_alux",  64'(bus.alu_x),  64'(100));
    chk("dz_aluy",  64'(bus.alu_y),  64'(7));
    chk("dz_aluop", 64'(bus.alu_op), 64'(OP_MOD));
    expect_res("dz", 33'h1_FFFF_FFFF, 1'b1, 4'd5);

    // Capacity with res_ready low: 4 queued + 1 in the engine.
    for (int i = 0; i < 6; i++) begin
      push(OP_ADD, 32'(i * 16), 32'd1, 4'(i), acc);
      chk($sformatf("cap_acc%0d", i), 64'(acc), 64'(i < 5));
    end
    chk("cap_rdy_full", 64'(bus.cmd_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      expect_res($sformatf("cap%0d", i), 33'(i * 16 + 1), 1'b0, 4'(i));
    end
    chk("cap_rdy_after", 64'(bus.cmd_ready), 64'(1));

    // Push and pop on the same edge at count 2.
    push(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd8,  acc);
    push(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9,  acc);
    push(OP_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd10, acc);
    @(negedge clk);
    chk("pp_cnt0", 64'(dut.fifo_cnt), 64'(2));
    expect_res("pp_a", 33'h0_FF00_FF00, 1'b0, 4'd8);
    push(OP_XNOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd11, acc);
    chk("pp_cnt1", 64'(dut.fifo_cnt), 64'(2));
    expect_res("pp_b", 33'h0_00F0_00F0, 1'b0, 4'd9);
    expect_res("pp_c", 33'h0_FFF0_FFF0, 1'b0, 4'd10);
    expect_res("pp_d", 33'h0_00FF_00FF, 1'b0, 4'd11);

    // Reset in WAIT with two commands still queued.
    push(OP_ADD, 32'd10, 32'd20, 4'd1, acc);
    push(OP_SUB, 32'd50, 32'd8,  4'd2, acc);
    push(OP_ADD, 32'd7,  32'd7,  4'd3, acc);
    push(OP_ADD, 32'd1,  32'd1,  4'd4, acc);
    expect_res("rs0", 33'd30, 1'b0, 4'd1);
    @(posedge clk);
    #1;
    chk("rs_pre_cnt",  64'(dut.fifo_cnt), 64'(2));
    chk("rs_pre_alux", 64'(bus.alu_x),    64'(50));
    rst_n = 1'b0;
    #1;
    chk("rs_vld",   64'(bus.res_valid), 64'(0));
    chk("rs_cnt",   64'(dut.fifo_cnt),  64'(0));
    chk("rs_alux",  64'(bus.alu_x),     64'(0));
    chk("rs_aluy",  64'(bus.alu_y),     64'(0));
    chk("rs_aluop", 64'(bus.alu_op),    64'(0));
    chk("rs_rdy",   64'(bus.cmd_ready), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("rs_quiet", 64'(seen), 64'(0));
    push(OP_ADD, 32'd1, 32'd2, 4'd7, acc);
    chk("rs_new_acc", 64'(acc), 64'(1));
    expect_res("rs_new", 33'd3, 1'b0, 4'd7);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
